// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Takes decoded instruction fields over a valid/ready handshake and packs
//   each set into the processor's 16-bit instruction format. It then writes
//   the words into instruction memory at consecutive (wrapping) addresses.
//   The processor is held in reset until the programmed word count has been
//   written.
//
// Optional build macro: INSTR_LOADER_CHECKSUM_EN adds the checksum output,
//   which is the XOR of every word written in the current session.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   start                 one-cycle pulse, begins a load session (ignored in LOAD)
//   start_addr            first instruction memory address of the session
//   prog_len              words to write, 0..32 (larger values saturate to 32)
//   fld_valid/fld_ready   field-set handshake
//   fld_opcode..offset    decoded fields to encode
//   im_wr_en/addr/data    instruction memory write port
//   cpu_rst_n             active-low processor reset, high only in DONE
//   done                  one-cycle pulse on the first DONE cycle
//   words_left            words still to be accepted in this session
//   checksum              (macro only) running XOR of written words
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, processor held in reset, waiting for start
// LOAD  | accepting field sets until words_left reaches zero
// DONE  | load complete, processor released, start begins a new session
module instr_encoder_loader #(
  parameter int INSTRUCTION_LEN      = 16,
  parameter int INSTRUCTION_MEM_SIZE = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [INSTRUCTION_MEM_SIZE-1:0] start_addr,
  input  logic [INSTRUCTION_MEM_SIZE:0]   prog_len,
  input  logic                            fld_valid,
  output logic                            fld_ready,
  input  logic [1:0]                      fld_opcode,
  input  logic [1:0]                      fld_alu_op,
  input  logic [3:0]                      fld_rd,
  input  logic [3:0]                      fld_rs1,
  input  logic [3:0]                      fld_rs2,
  input  logic [3:0]                      fld_offset,
  output logic                            im_wr_en,
  output logic [INSTRUCTION_MEM_SIZE-1:0] im_wr_addr,
  output logic [INSTRUCTION_LEN-1:0]      im_wr_data,
  output logic                            cpu_rst_n,
  output logic                            done,
  output logic [INSTRUCTION_MEM_SIZE:0]   words_left
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [INSTRUCTION_LEN-1:0]      checksum
`endif
);

  localparam int CNT_W = INSTRUCTION_MEM_SIZE + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << INSTRUCTION_MEM_SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_R_FORMAT = 2'd0;
  localparam logic [1:0] OP_BEQ      = 2'd1;
  localparam logic [1:0] OP_LD       = 2'd2;

  state_t                          state_q;
  state_t                          state_d;
  logic [INSTRUCTION_MEM_SIZE-1:0] wr_ptr;
  logic [CNT_W-1:0]                sat_len;
  logic [INSTRUCTION_LEN-1:0]      enc_word;
  logic                            start_accept;
  logic                            xfer;

  // start is only honoured outside LOAD so a session cannot be cut short
  assign start_accept = start && (state_q != S_LOAD);
  assign sat_len      = (prog_len > MAX_WORDS) ? MAX_WORDS : prog_len;
  assign fld_ready    = (state_q == S_LOAD) && (words_left != '0);
  assign xfer         = fld_valid && fld_ready;
  assign cpu_rst_n    = (state_q == S_DONE);

  // opcode and alu_op always occupy the top nibble; the low 12 bits depend on format
  always_comb begin
    enc_word = '0;
    case (fld_opcode)
      OP_R_FORMAT: enc_word = {fld_opcode, fld_alu_op, fld_rd,     fld_rs1,    fld_rs2};
      OP_BEQ:      enc_word = {fld_opcode, fld_alu_op, fld_offset, fld_rs1,    fld_rs2};
      OP_LD:       enc_word = {fld_opcode, fld_alu_op, fld_rd,     fld_offset, fld_rs1};
      default:     enc_word = {fld_opcode, fld_alu_op, fld_offset, fld_rs1,    fld_rs2};
    endcase
  end

  // LOAD exits one cycle after words_left hits zero, so the last write is
  // already on the bus when cpu_rst_n rises.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)              state_d = S_LOAD;
      S_LOAD:  if (words_left == '0)   state_d = S_DONE;
      S_DONE:  if (start)              state_d = S_LOAD;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      words_left <= '0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      done       <= 1'b0;
    end else begin
      state_q  <= state_d;
      im_wr_en <= xfer;
      done     <= (state_q == S_LOAD) && (state_d == S_DONE);
      if (start_accept) begin
        wr_ptr     <= start_addr;
        words_left <= sat_len;
      end else if (xfer) begin
        im_wr_addr <= wr_ptr;
        im_wr_data <= enc_word;
        wr_ptr     <= wr_ptr + INSTRUCTION_MEM_SIZE'(1);
        words_left <= words_left - CNT_W'(1);
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (start_accept) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum ^ enc_word;
    end
  end
`endif

endmodule
